// File: rtl/conv2_stream.sv
// conv2_stream: streaming 2-D convolution over a raster-order signed image.
// Pixels enter through a valid/ready port. KER-1 line buffers and a KER x KER
// window register track the most recent rows. Each window position selected by
// STRIDE gives one signed, saturated result through a registered valid/ready
// output port. The kernel coefficients are loaded through a simple write port
// while the block is idle.
module conv2_stream #(
    parameter int IMG_W     = 7,
    parameter int IMG_H     = 7,
    parameter int KER       = 3,
    parameter int WIDTH_BIT = 16,
    parameter int STRIDE    = 1,
    localparam int KK       = KER * KER,
    localparam int AW       = (KK > 1) ? $clog2(KK) : 1
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    input  logic                        ker_we,
    input  logic [AW-1:0]               ker_addr,
    input  logic signed [WIDTH_BIT-1:0] ker_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH_BIT-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic                        busy,
    output logic                        done
);

    localparam int ACC_W   = 2 * WIDTH_BIT + $clog2(KK);
    localparam int LB_ROWS = (KER > 1) ? KER - 1 : 1;
    localparam int CWW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int CWH     = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CWW-1:0] COL_LAST  = CWW'(IMG_W - 1);
    localparam logic [CWW-1:0] COL_FIRST = CWW'(KER - 1);
    localparam logic [CWH-1:0] ROW_LAST  = CWH'(IMG_H - 1);
    localparam logic [CWH-1:0] ROW_FIRST = CWH'(KER - 1);
    localparam logic [PW-1:0]  PH_LAST   = PW'(STRIDE - 1);

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] ACC_MAX =
        {{(ACC_W - WIDTH_BIT + 1){1'b0}}, {(WIDTH_BIT - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {{(ACC_W - WIDTH_BIT + 1){1'b1}}, {(WIDTH_BIT - 1){1'b0}}};
    localparam logic signed [WIDTH_BIT-1:0] OUT_MAX = {1'b0, {(WIDTH_BIT - 1){1'b1}}};
    localparam logic signed [WIDTH_BIT-1:0] OUT_MIN = {1'b1, {(WIDTH_BIT - 1){1'b0}}};

    // Clamp a full-precision sum into the signed output range
    function automatic logic signed [WIDTH_BIT-1:0] sat_fn(input logic signed [ACC_W-1:0] v);
        logic signed [WIDTH_BIT-1:0] res;
        if (v > ACC_MAX) begin
            res = OUT_MAX;
        end else if (v < ACC_MIN) begin
            res = OUT_MIN;
        end else begin
            res = v[WIDTH_BIT-1:0];
        end
        return res;
    endfunction

    // Sign-extend a pixel or coefficient to accumulator width
    function automatic logic signed [ACC_W-1:0] ext_fn(input logic signed [WIDTH_BIT-1:0] v);
        return {{(ACC_W - WIDTH_BIT){v[WIDTH_BIT-1]}}, v};
    endfunction

    logic [1:0]                  r_state;
    logic [CWH-1:0]              r_row;
    logic [CWW-1:0]              r_col;
    logic [PW-1:0]               r_row_ph;
    logic [PW-1:0]               r_col_ph;
    logic signed [WIDTH_BIT-1:0] r_coef [KK];
    logic signed [WIDTH_BIT-1:0] r_lb   [LB_ROWS][IMG_W];
    logic signed [WIDTH_BIT-1:0] r_win  [KER][KER];
    logic                        r_out_valid;
    logic signed [WIDTH_BIT-1:0] r_out_data;
    logic                        r_busy;
    logic                        r_done;

    logic [1:0]                  w_state_n;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_hit;
    logic signed [WIDTH_BIT-1:0] w_col   [KER];
    logic signed [WIDTH_BIT-1:0] w_win_n [KER][KER];
    logic signed [ACC_W-1:0]     w_acc;

    // A pixel moves only while running and the output slot is free or draining
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_accept   = in_valid && w_in_ready;
    assign w_last     = w_accept && (r_row == ROW_LAST) && (r_col == COL_LAST);
    // The accepted pixel completes a window that lies on the stride grid
    assign w_hit      = (r_row >= ROW_FIRST) && (r_row_ph == {PW{1'b0}}) &&
                        (r_col >= COL_FIRST) && (r_col_ph == {PW{1'b0}});

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

    // Next-state selection for the frame controller
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_RUN;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_n = ST_DRAIN;
                end else begin
                    w_state_n = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid) begin
                    w_state_n = ST_DONE;
                end else begin
                    w_state_n = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // Controller state plus registered busy/done flags aligned with it
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_busy  <= (w_state_n == ST_RUN) || (w_state_n == ST_DRAIN);
            r_done  <= (w_state_n == ST_DONE);
        end
    end

    // Raster position and stride phase of the next pixel to arrive
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_row    <= {CWH{1'b0}};
            r_col    <= {CWW{1'b0}};
            r_row_ph <= {PW{1'b0}};
            r_col_ph <= {PW{1'b0}};
        end else if ((r_state == ST_IDLE) && start) begin
            r_row    <= {CWH{1'b0}};
            r_col    <= {CWW{1'b0}};
            r_row_ph <= {PW{1'b0}};
            r_col_ph <= {PW{1'b0}};
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                r_col    <= {CWW{1'b0}};
                r_col_ph <= {PW{1'b0}};
                if (r_row == ROW_LAST) begin
                    r_row <= {CWH{1'b0}};
                end else begin
                    r_row <= r_row + CWH'(1);
                end
                if ((r_row < ROW_FIRST) || (r_row_ph == PH_LAST)) begin
                    r_row_ph <= {PW{1'b0}};
                end else begin
                    r_row_ph <= r_row_ph + PW'(1);
                end
            end else begin
                r_col <= r_col + CWW'(1);
                if ((r_col < COL_FIRST) || (r_col_ph == PH_LAST)) begin
                    r_col_ph <= {PW{1'b0}};
                end else begin
                    r_col_ph <= r_col_ph + PW'(1);
                end
            end
        end
    end

    // Coefficient store, writable only while idle
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < KK; k++) begin
                r_coef[k] <= {WIDTH_BIT{1'b0}};
            end
        end else if (ker_we && (r_state == ST_IDLE) && (int'(ker_addr) < KK)) begin
            r_coef[ker_addr] <= ker_data;
        end
    end

    // New window column (oldest row on top) and the window after shifting
    always_comb begin
        for (int i = 0; i < KER - 1; i++) begin
            w_col[i] = r_lb[i][r_col];
        end
        w_col[KER-1] = in_data;
        for (int i = 0; i < KER; i++) begin
            for (int j = 0; j < KER - 1; j++) begin
                w_win_n[i][j] = r_win[i][j+1];
            end
            w_win_n[i][KER-1] = w_col[i];
        end
    end

    // Line buffers: each column moves up one row as the new pixel arrives
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < LB_ROWS; k++) begin
                for (int c = 0; c < IMG_W; c++) begin
                    r_lb[k][c] <= {WIDTH_BIT{1'b0}};
                end
            end
        end else if (w_accept) begin
            for (int k = 0; k < LB_ROWS - 1; k++) begin
                r_lb[k][r_col] <= r_lb[k+1][r_col];
            end
            r_lb[LB_ROWS-1][r_col] <= in_data;
        end
    end

    // Window register follows the shifted window on every accepted pixel
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < KER; i++) begin
                for (int j = 0; j < KER; j++) begin
                    r_win[i][j] <= {WIDTH_BIT{1'b0}};
                end
            end
        end else if (w_accept) begin
            for (int i = 0; i < KER; i++) begin
                for (int j = 0; j < KER; j++) begin
                    r_win[i][j] <= w_win_n[i][j];
                end
            end
        end
    end

    // Full-precision multiply-accumulate over the post-shift window
    always_comb begin
        w_acc = {ACC_W{1'b0}};
        for (int i = 0; i < KER; i++) begin
            for (int j = 0; j < KER; j++) begin
                w_acc = w_acc + ext_fn(w_win_n[i][j]) * ext_fn(r_coef[i*KER+j]);
            end
        end
    end

    // Output slot: load on a completing pixel, clear once the consumer takes it
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH_BIT{1'b0}};
        end else if (w_accept && w_hit) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sat_fn(w_acc);
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
